counter_sweep_ctrl: RTL and testbench

Sequencer for the 4-bit load/up-down counter. It accepts a sweep command with origin, target, pass count and bounce mode over a valid/ready handshake. It then drives the counter's load, jump, up_down and enable inputs, and watches the counter's q to detect the end of each pass. It signals completion with a one-cycle done pulse, or an aborted pulse if the sweep is cancelled.

---
 rtl/counter_sweep_ctrl.sv | 105 ++++++++++
 tb/tb_counter_sweep_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for a 4-bit load/up-down counter: runs (reps+1) passes between
// origin and target, optionally bouncing direction, with done/aborted pulses.
module counter_sweep_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned REPS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_start,
    input  logic [WIDTH-1:0]  cmd_end,
    input  logic [REPS_W-1:0] cmd_reps,
    input  logic              cmd_bounce,
    input  logic              abort,
    input  logic [WIDTH-1:0]  cnt_q,
    output logic              cnt_load,
    output logic [WIDTH-1:0]  cnt_jump,
    output logic              cnt_up_down,
    output logic              cnt_enable,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [REPS_W-1:0] pass_idx
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StAbrt} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  origin_q;
    logic [WIDTH-1:0]  target_q;
    logic [REPS_W-1:0] reps_q;
    logic [REPS_W-1:0] pass_idx_q;
    logic              bounce_q;

    logic dir;
    logic at_target;

    // Counting toward the target in this direction can never wrap the counter.
    assign dir       = (target_q >= origin_q);
    assign at_target = (cnt_q == target_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            origin_q   <= '0;
            target_q   <= '0;
            reps_q     <= '0;
            pass_idx_q <= '0;
            bounce_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        origin_q   <= cmd_start;
                        target_q   <= cmd_end;
                        reps_q     <= cmd_reps;
                        bounce_q   <= cmd_bounce;
                        pass_idx_q <= '0;
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    state_q <= abort ? StAbrt : StRun;
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StAbrt;
                    end else if (at_target) begin
                        if (pass_idx_q == reps_q) begin
                            state_q <= StDone;
                        end else begin
                            pass_idx_q <= pass_idx_q + 1'b1;
                            state_q    <= StLoad;
                            if (bounce_q) begin
                                origin_q <= target_q;
                                target_q <= origin_q;
                            end
                        end
                    end
                end
                StDone, StAbrt: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        cmd_ready   = (state_q == StIdle);
        busy        = (state_q == StLoad) || (state_q == StRun);
        done        = (state_q == StDone);
        aborted     = (state_q == StAbrt);
        cnt_load    = (state_q == StLoad) && !abort;
        cnt_jump    = (state_q == StLoad) ? origin_q : '0;
        cnt_up_down = busy ? dir : 1'b0;
        // Abort gates the counter in the same cycle it is raised.
        cnt_enable  = !abort && ((state_q == StLoad) || ((state_q == StRun) && !at_target));
        pass_idx    = pass_idx_q;
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Randomized bench for counter_sweep_ctrl driving a behavioural 4-bit counter; each
// sweep is expanded into an expected per-cycle trace from the pass rules.
module tb_counter_sweep_ctrl;

    localparam int WIDTH  = 4;
    localparam int REPS_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_start = '0;
    logic [WIDTH-1:0]  cmd_end = '0;
    logic [REPS_W-1:0] cmd_reps = '0;
    logic              cmd_bounce = 1'b0;
    logic              abort = 1'b0;
    logic [WIDTH-1:0]  cnt_q;
    logic              cnt_load;
    logic [WIDTH-1:0]  cnt_jump;
    logic              cnt_up_down;
    logic              cnt_enable;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [REPS_W-1:0] pass_idx;

    always #5 clk = ~clk;

    counter_sweep_ctrl #(.WIDTH(WIDTH), .REPS_W(REPS_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_start   (cmd_start),
        .cmd_end     (cmd_end),
        .cmd_reps    (cmd_reps),
        .cmd_bounce  (cmd_bounce),
        .abort       (abort),
        .cnt_q       (cnt_q),
        .cnt_load    (cnt_load),
        .cnt_jump    (cnt_jump),
        .cnt_up_down (cnt_up_down),
        .cnt_enable  (cnt_enable),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .pass_idx    (pass_idx)
    );

    // Behavioural load/up-down counter controlled by the DUT.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (cnt_enable) cnt_q <= cnt_load ? cnt_jump :
                                      (cnt_up_down ? cnt_q + 4'd1 : cnt_q - 4'd1);
    end

    typedef struct {
        bit ready, busy, load, en, ud, done, abrt;
        int jump, pidx, q;
    } exp_t;

    exp_t trace[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q    = 0;
    int   sweep_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic string tg(input int i, input string n);
        return $sformatf("sweep%0d.cyc%0d.%s", sweep_no, i, n);
    endfunction

    task automatic add(input bit ready, input bit bsy, input bit load, input bit en,
                       input int jump, input bit ud, input bit dn, input bit ab,
                       input int pidx, input int q);
        exp_t e;
        e.ready = ready; e.busy = bsy; e.load = load; e.en = en; e.jump = jump;
        e.ud = ud; e.done = dn; e.abrt = ab; e.pidx = pidx; e.q = q;
        trace.push_back(e);
    endtask

    // Expands a command into its LOAD/RUN cycles from the pass rules.
    task automatic build_trace(input int s, input int e, input int r, input int b);
        int o = s;
        int t = e;
        int q = exp_q;
        int tmp;
        trace.delete();
        for (int p = 0; p <= r; p++) begin
            add(0, 1, 1, 1, o, t >= o, 0, 0, p, q);
            q = o;
            while (q != t) begin
                add(0, 1, 0, 1, 0, t >= o, 0, 0, p, q);
                q = (t > q) ? q + 1 : q - 1;
            end
            add(0, 1, 0, 0, 0, t >= o, 0, 0, p, t);
            if (b != 0) begin
                tmp = o; o = t; t = tmp;
            end
        end
    endtask

    task automatic do_sweep(input int s, input int e, input int r, input int b,
                            input int abort_at_in, input bit hold,
                            input int ns, input int ne, input int nr, input int nb,
                            input bit skip_accept);
        int abort_at = abort_at_in;
        int n_live;
        int last_q;
        int last_p;
        exp_t x;
        sweep_no++;
        if (!skip_accept) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; abort = 1'b0;
            cmd_start = s[3:0]; cmd_end = e[3:0]; cmd_reps = r[3:0]; cmd_bounce = b[0];
            @(negedge clk);
            check_eq(tg(-1, "accept_ready"), cmd_ready, 1);
        end
        build_trace(s, e, r, b);
        if (abort_at == -2)
            abort_at = ($urandom_range(3) == 0) ? int'($urandom_range(trace.size() - 1)) : -1;
        if (abort_at >= 0) begin
            while (trace.size() > abort_at + 1) void'(trace.pop_back());
            trace[abort_at].en   = 0;
            trace[abort_at].load = 0;
            last_q = trace[abort_at].q;
            last_p = trace[abort_at].pidx;
            n_live = trace.size();
            add(0, 0, 0, 0, 0, 0, 0, 1, last_p, last_q);
        end else begin
            last_q = trace[trace.size() - 1].q;
            last_p = r;
            n_live = trace.size();
            add(0, 0, 0, 0, 0, 0, 1, 0, last_p, last_q);
        end
        add(1, 0, 0, 0, 0, 0, 0, 0, last_p, last_q);
        exp_q = last_q;

        for (int i = 0; i < trace.size(); i++) begin
            @(posedge clk); #1;
            abort = (i == abort_at) || (i >= n_live && $urandom_range(1) == 1);
            if (hold) begin
                cmd_valid = 1'b1;
                cmd_start = ns[3:0]; cmd_end = ne[3:0]; cmd_reps = nr[3:0]; cmd_bounce = nb[0];
            end else begin
                cmd_valid = 1'b0;
                cmd_start = 4'($urandom); cmd_end = 4'($urandom);
                cmd_reps = 4'($urandom); cmd_bounce = 1'($urandom);
            end
            @(negedge clk);
            x = trace[i];
            check_eq(tg(i, "cmd_ready"), cmd_ready, x.ready);
            check_eq(tg(i, "busy"), busy, x.busy);
            check_eq(tg(i, "cnt_load"), cnt_load, x.load);
            check_eq(tg(i, "cnt_enable"), cnt_enable, x.en);
            check_eq(tg(i, "done"), done, x.done);
            check_eq(tg(i, "aborted"), aborted, x.abrt);
            check_eq(tg(i, "pass_idx"), pass_idx, x.pidx);
            check_eq(tg(i, "cnt_q"), cnt_q, x.q);
            if (x.load) check_eq(tg(i, "cnt_jump"), cnt_jump, x.jump);
            if (x.en) check_eq(tg(i, "cnt_up_down"), cnt_up_down, x.ud);
        end
        abort = 1'b0;
    endtask

    initial begin
        int cs, ce, cr, cb, ns, ne, nr, nb;
        bit h, chained;

        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst.cmd_ready", cmd_ready, 1);
        check_eq("rst.busy", busy, 0);
        check_eq("rst.cnt_enable", cnt_enable, 0);
        check_eq("rst.cnt_load", cnt_load, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.aborted", aborted, 0);
        check_eq("rst.pass_idx", pass_idx, 0);
        exp_q = 0;

        do_sweep(2, 5, 0, 0, -1, 0, 0, 0, 0, 0, 0);
        do_sweep(9, 6, 1, 1, -1, 0, 0, 0, 0, 0, 0);
        do_sweep(0, 15, 2, 0, -1, 0, 0, 0, 0, 0, 0);
        do_sweep(2, 5, 0, 0, 2, 0, 0, 0, 0, 0, 0);   // abort while cnt_q == 3
        do_sweep(7, 7, 3, 0, -1, 0, 0, 0, 0, 0, 0);
        do_sweep(2, 5, 0, 0, -1, 1, 9, 6, 1, 1, 0);  // second command held while busy
        do_sweep(9, 6, 1, 1, -1, 0, 0, 0, 0, 0, 1);

        // Reset mid-RUN.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_start = 4'd3; cmd_end = 4'd12; cmd_reps = 4'd1; cmd_bounce = 1'b0;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        check_eq("midrst.busy_before", busy, 1);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check_eq("midrst.busy", busy, 0);
        check_eq("midrst.done", done, 0);
        check_eq("midrst.aborted", aborted, 0);
        check_eq("midrst.cnt_enable", cnt_enable, 0);
        check_eq("midrst.pass_idx", pass_idx, 0);
        check_eq("midrst.cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("midrst.done_next", done, 0);
        check_eq("midrst.aborted_next", aborted, 0);
        exp_q = 0;

        chained = 0;
        cs = $urandom_range(15); ce = $urandom_range(15);
        cr = $urandom_range(3);  cb = $urandom_range(1);
        for (int it = 0; it < 40; it++) begin
            ns = $urandom_range(15); ne = $urandom_range(15);
            nr = $urandom_range(3);  nb = $urandom_range(1);
            h = (it < 39) ? bit'($urandom_range(1)) : 1'b0;
            do_sweep(cs, ce, cr, cb, -2, h, ns, ne, nr, nb, chained);
            chained = h;
            cs = ns; ce = ne; cr = nr; cb = nb;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
